// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced one-hot decoder: command modes and
// the controller state encoding.
package decoder_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEVEL = 2'b01,
    ST_PULSE = 2'b10,
    ST_SCAN  = 2'b11
  } state_t;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N:2^N one-hot decoder. It has no enable. Gating happens in
// the parent module.
module decoder_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0]      addr,
  output logic [(2**N)-1:0] onehot
);

  // Exactly one bit set, selected by addr.
  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a command handshake. It supports level
// hold, single-cycle pulse, timed address scan and clear.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on state, abort and rst.
// It never depends on cmd_valid. A held cmd_valid waits until ready.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [N-1:0]      cmd_addr,
  input  logic [N-1:0]      cmd_last,
  input  logic              abort,
  output logic [(2**N)-1:0] d,
  output logic [N-1:0]      cur_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int         W      = 2**N;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_t         state, state_n;
  logic [W-1:0]   d_reg, d_n;
  logic [N-1:0]   cur_n, last_q, last_n;
  logic [7:0]     cnt, cnt_n;
  logic           done_n;
  logic [N-1:0]   oh_addr;
  logic [W-1:0]   oh_val;

  // One decoder serves both sources: the next scan address while scanning,
  // and the incoming command address otherwise.
  assign oh_addr = (state == ST_SCAN) ? (cur_addr + ONE) : cmd_addr;

  decoder_onehot #(.N(N)) u_onehot (
    .addr   (oh_addr),
    .onehot (oh_val)
  );

  // State and output registers. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      d_reg    <= '0;
      cur_addr <= '0;
      last_q   <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      d_reg    <= d_n;
      cur_addr <= cur_n;
      last_q   <= last_n;
      cnt      <= cnt_n;
      done     <= done_n;
    end
  end

  // Next-state logic. abort overrides everything. Commands are taken only in
  // IDLE and LEVEL.
  always_comb begin
    state_n = state;
    d_n     = d_reg;
    cur_n   = cur_addr;
    last_n  = last_q;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
      d_n     = '0;
    end else begin
      case (state)
        ST_IDLE, ST_LEVEL: begin
          if (cmd_valid) begin
            case (cmd_mode)
              MODE_LEVEL: begin
                d_n     = oh_val;
                cur_n   = cmd_addr;
                state_n = ST_LEVEL;
              end
              MODE_PULSE: begin
                d_n     = oh_val;
                cur_n   = cmd_addr;
                state_n = ST_PULSE;
              end
              MODE_SCAN: begin
                d_n     = oh_val;
                cur_n   = cmd_addr;
                last_n  = cmd_last;
                cnt_n   = RELOAD;
                state_n = ST_SCAN;
              end
              default: begin
                d_n     = '0;
                state_n = ST_IDLE;
              end
            endcase
          end
        end
        ST_PULSE: begin
          d_n     = '0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
        ST_SCAN: begin
          if (cnt == 8'd0) begin
            if (cur_addr == last_q) begin
              d_n     = '0;
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              cur_n = cur_addr + ONE;
              d_n   = oh_val;
              cnt_n = RELOAD;
            end
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        default: begin
          d_n     = '0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ((state == ST_IDLE) || (state == ST_LEVEL)) && !abort && !rst;
  assign busy      = (state == ST_PULSE) || (state == ST_SCAN);
  assign d         = d_reg & {W{en}};
  assign dbg_state = state;

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq. It runs directed cases on an N=4/DWELL=2 instance.
// It then runs randomized commands on N=3/DWELL=3 and N=5/DWELL=1 instances.
// Each random instance is compared against a cycle-position model.
module tb_decoder_seq;
  import decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- N=4, DWELL=2 instance (directed) ----------------
  logic        en = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [1:0]  cmd_mode = 2'b00;
  logic [3:0]  cmd_addr = '0, cmd_last = '0;
  logic        cmd_ready, busy, done;
  logic [15:0] d;
  logic [3:0]  cur_addr;
  logic [1:0]  dbg_state;

  decoder_seq #(.N(4), .DWELL(2)) u4 (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_addr(cmd_addr), .cmd_last(cmd_last), .abort(abort),
    .d(d), .cur_addr(cur_addr), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- N=3, DWELL=3 instance (random) ----------------
  logic       en3 = 1'b1, v3 = 1'b0, ab3 = 1'b0;
  logic [1:0] mode3 = '0;
  logic [2:0] addr3 = '0, last3 = '0, cur3;
  logic [7:0] d3;
  logic       rdy3, busy3, done3;
  logic [1:0] st3;

  decoder_seq #(.N(3), .DWELL(3)) u3 (
    .clk(clk), .rst(rst), .en(en3), .cmd_valid(v3), .cmd_ready(rdy3),
    .cmd_mode(mode3), .cmd_addr(addr3), .cmd_last(last3), .abort(ab3),
    .d(d3), .cur_addr(cur3), .busy(busy3), .done(done3), .dbg_state(st3)
  );

  // ---------------- N=5, DWELL=1 instance (random) ----------------
  logic        en5 = 1'b1, v5 = 1'b0, ab5 = 1'b0;
  logic [1:0]  mode5 = '0;
  logic [4:0]  addr5 = '0, last5 = '0, cur5;
  logic [31:0] d5;
  logic        rdy5, busy5, done5;
  logic [1:0]  st5;

  decoder_seq #(.N(5), .DWELL(1)) u5 (
    .clk(clk), .rst(rst), .en(en5), .cmd_valid(v5), .cmd_ready(rdy5),
    .cmd_mode(mode5), .cmd_addr(addr5), .cmd_last(last5), .abort(ab5),
    .d(d5), .cur_addr(cur5), .busy(busy5), .done(done5), .dbg_state(st5)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A command is tracked by its start address and by how many cycles have
  // elapsed since it was accepted. The displayed address is
  // start + elapsed/DWELL. Completion is at elapsed == DWELL*length.
  int m_size[2], m_dw[2];
  int m_curd[2], m_cura[2], m_start[2], m_pos[2], m_total[2];
  bit m_active[2], m_done[2];
  int m_ndone[2], obs_ndone[2];

  task automatic model_reset(input int i, input int size, input int dw);
    m_size[i] = size; m_dw[i] = dw;
    m_curd[i] = -1; m_cura[i] = 0; m_start[i] = 0; m_pos[i] = 0; m_total[i] = 0;
    m_active[i] = 0; m_done[i] = 0; m_ndone[i] = 0; obs_ndone[i] = 0;
  endtask

  task automatic model_step(input int i, input bit v, input int mode, input int addr,
                            input int last, input bit ab);
    m_done[i] = 0;
    if (ab) begin
      m_active[i] = 0;
      m_curd[i]   = -1;
    end else if (m_active[i]) begin
      m_pos[i]++;
      if (m_pos[i] == m_total[i]) begin
        m_active[i] = 0;
        m_curd[i]   = -1;
        m_done[i]   = 1;
        m_ndone[i]++;
      end else begin
        m_curd[i] = (m_start[i] + m_pos[i] / m_dw[i]) % m_size[i];
        m_cura[i] = m_curd[i];
      end
    end else if (v) begin
      case (mode)
        0: begin m_curd[i] = addr; m_cura[i] = addr; end
        1: begin
          m_active[i] = 1; m_start[i] = addr; m_pos[i] = 0; m_total[i] = 1;
          m_curd[i] = addr; m_cura[i] = addr;
        end
        2: begin
          m_active[i] = 1; m_start[i] = addr; m_pos[i] = 0;
          m_total[i] = m_dw[i] * ((((last - addr) % m_size[i]) + m_size[i]) % m_size[i] + 1);
          m_curd[i] = addr; m_cura[i] = addr;
        end
        default: m_curd[i] = -1;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_d(input int i, input bit e);
    if (e && m_curd[i] >= 0) return 32'd1 << m_curd[i];
    return 32'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] a, input logic [3:0] l);
    cmd_mode = m; cmd_addr = a; cmd_last = l; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] scan_exp [4];

  initial begin
    scan_exp = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};

    // Reset state.
    #3;
    check("rst_d", d, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cur", cur_addr, 0);
    check("rst_ready", cmd_ready, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("idle_ready", cmd_ready, 1);

    // LEVEL hold, enable gating, and replacement with no gap.
    send(MODE_LEVEL, 4'd5, 4'd0);
    check("lvl5_d", d, 16'h0020);
    check("lvl5_busy", busy, 0);
    check("lvl5_cur", cur_addr, 5);
    tick();
    check("lvl5_hold", d, 16'h0020);
    en = 1'b0; #1;
    check("en_off_d", d, 0);
    check("en_off_cur", cur_addr, 5);
    en = 1'b1; #1;
    check("lvl5_pre9", d, 16'h0020);
    send(MODE_LEVEL, 4'd9, 4'd0);
    check("lvl9_d", d, 16'h0200);

    // PULSE: one cycle high, then zero together with done.
    send(MODE_PULSE, 4'd15, 4'd0);
    check("pulse_d", d, 16'h8000);
    check("pulse_busy", busy, 1);
    check("pulse_ready", cmd_ready, 0);
    check("pulse_done0", done, 0);
    tick();
    check("pulse_d0", d, 0);
    check("pulse_done", done, 1);
    check("pulse_idle", busy, 0);
    tick();
    check("pulse_done_off", done, 0);

    // SCAN 14 to 1 with wrap. cmd_valid stays high throughout.
    cmd_mode = MODE_SCAN; cmd_addr = 4'd14; cmd_last = 4'd1; cmd_valid = 1'b1;
    tick();
    cmd_mode = MODE_LEVEL; cmd_addr = 4'd7;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan_d%0d", i), d, scan_exp[i/2]);
      check($sformatf("scan_rdy%0d", i), cmd_ready, 0);
      check($sformatf("scan_done%0d", i), done, 0);
      tick();
    end
    check("scan_end_d", d, 0);
    check("scan_end_done", done, 1);
    check("scan_end_rdy", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("held_cmd_d", d, 16'h0080);
    check("held_cmd_done", done, 0);

    // SCAN 3 to 8, aborted in its third cycle.
    send(MODE_SCAN, 4'd3, 4'd8);
    tick(); tick();
    check("abort_pre_d", d, 16'h0010);
    abort = 1'b1; #1;
    check("abort_rdy", cmd_ready, 0);
    tick();
    abort = 1'b0; #1;
    check("abort_d", d, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_cur", cur_addr, 4);
    // abort beats a simultaneous command.
    abort = 1'b1; cmd_valid = 1'b1; cmd_mode = MODE_LEVEL; cmd_addr = 4'd6; #1;
    check("abortcmd_rdy", cmd_ready, 0);
    tick();
    abort = 1'b0; cmd_valid = 1'b0;
    check("abortcmd_d", d, 0);
    check("abortcmd_cur", cur_addr, 4);

    // Asynchronous reset in the middle of a scan.
    send(MODE_SCAN, 4'd5, 4'd12);
    tick();
    check("pre_rst_cur", cur_addr, 5);
    #3 rst = 1'b1;
    #1;
    check("arst_d", d, 0);
    check("arst_busy", busy, 0);
    check("arst_cur", cur_addr, 0);
    check("arst_done", done, 0);
    #2 rst = 1'b0;
    tick();
    check("arst_after_done", done, 0);
    send(MODE_LEVEL, 4'd2, 4'd0);
    check("lvl2_d", d, 16'h0004);
    send(MODE_CLEAR, 4'd0, 4'd0);
    check("clear_d", d, 0);
    check("clear_done", done, 0);
    check("clear_busy", busy, 0);
    check("clear_state", dbg_state, ST_IDLE);
    tick();
    check("clear_done2", done, 0);

    // Randomized commands on the N=3 and N=5 instances.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset(0, 8, 3);
    model_reset(1, 32, 1);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      model_step(0, v3, int'(mode3), int'(addr3), int'(last3), ab3);
      model_step(1, v5, int'(mode5), int'(addr5), int'(last5), ab5);
      #1;
      if (c < 560) begin
        v3 = ($urandom_range(0, 99) < 40); mode3 = 2'($urandom_range(0, 3));
        addr3 = 3'($urandom_range(0, 7)); last3 = 3'($urandom_range(0, 7));
        ab3 = ($urandom_range(0, 99) < 4); en3 = ($urandom_range(0, 9) != 0);
        v5 = ($urandom_range(0, 99) < 40); mode5 = 2'($urandom_range(0, 3));
        addr5 = 5'($urandom_range(0, 31)); last5 = 5'($urandom_range(0, 31));
        ab5 = ($urandom_range(0, 99) < 4); en5 = ($urandom_range(0, 9) != 0);
      end else begin
        v3 = 1'b0; ab3 = 1'b0; v5 = 1'b0; ab5 = 1'b0;
      end
      #1;
      check("r3_d", d3, exp_d(0, en3));
      check("r3_cur", cur3, m_cura[0]);
      check("r3_busy", busy3, m_active[0]);
      check("r3_done", done3, m_done[0]);
      check("r3_ready", rdy3, !m_active[0] && !ab3);
      check("r3_onehot", $onehot0(d3), 1);
      check("r3_state", (st3 == ST_PULSE) || (st3 == ST_SCAN), m_active[0]);
      check("r5_d", d5, exp_d(1, en5));
      check("r5_cur", cur5, m_cura[1]);
      check("r5_busy", busy5, m_active[1]);
      check("r5_done", done5, m_done[1]);
      check("r5_ready", rdy5, !m_active[1] && !ab5);
      check("r5_onehot", $onehot0(d5), 1);
      check("r5_state", (st5 == ST_PULSE) || (st5 == ST_SCAN), m_active[1]);
      obs_ndone[0] += int'(done3);
      obs_ndone[1] += int'(done5);
    end
    check("r3_done_count", obs_ndone[0], m_ndone[0]);
    check("r5_done_count", obs_ndone[1], m_ndone[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered N:2^N one-hot decoder with a command handshake and four modes: level hold, single-cycle pulse, timed address scan, and clear.
- Drives row and write-select lines in the register-file and memory-array datapaths, where the plain combinational 4:16 select is no longer enough.
- Sequencing such as scan/refresh walks or single-shot strobes runs internally, so controllers issue one command instead of stepping addresses every cycle.

Parameters:
- N, 4: select width. Output width is 2^N.
- DWELL, 1: clock cycles each address is held during SCAN. Legal range is 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  output gate. d = d_reg & {2^N{en}}, combinational. Internal sequencing is unaffected by en.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are both high at a rising edge.
- cmd_mode  in  2  command mode: 00 LEVEL, 01 PULSE, 10 SCAN, 11 CLEAR.
- cmd_addr  in  N  start/target address.
- cmd_last  in  N  final address for SCAN; ignored in other modes.
- abort  in  1  synchronous abort.
- d  out  2^N  one-hot or all-zero select.
- cur_addr  out  N  address currently driven by d_reg.
- busy  out  1  high in PULSE and SCAN states.
- done  out  1  one-cycle completion strobe.

Behaviour:
- Reset (asynchronous): state=IDLE, d_reg=0, cur_addr=0, busy=0, done=0, dwell counter=0. cmd_ready is 0 while rst is high.
- States: IDLE, LEVEL, PULSE, SCAN.
- cmd_ready = (state==IDLE or LEVEL) & ~abort & ~rst.
- IDLE/LEVEL, on accept (edge k); d_reg updates at edge k, so the new value is visible in cycle k+1:
  - LEVEL: d_reg=onehot(cmd_addr), cur_addr=cmd_addr, go to LEVEL. Held indefinitely; a new command replaces it with no zero gap.
  - PULSE: d_reg=onehot(cmd_addr), go to PULSE. The next edge clears d_reg, pulses done for 1 cycle (visible together with d=0), and returns to IDLE. d is high for exactly 1 cycle.
  - SCAN: d_reg=onehot(cmd_addr), dwell counter=DWELL-1, go to SCAN.
  - CLEAR: d_reg=0, go to IDLE. No done.
- SCAN stepping:
  - Each edge decrements the dwell counter.
  - At counter==0 with cur_addr != cmd_last (latched): cur_addr=cur_addr+1 mod 2^N, counter reloads to DWELL-1.
  - At counter==0 with cur_addr == last: d_reg=0, done=1 for one cycle, go to IDLE.
  - Wrap-around is legal: last < addr walks through 2^N-1 and then 0.
  - addr==last gives a one-address scan of DWELL cycles.
  - Total active cycles = DWELL*(((last-addr) mod 2^N)+1).
- Commands are not accepted in PULSE or SCAN (cmd_ready=0). cmd_valid held high is accepted on the first ready edge.
- abort:
  - In any state, the next edge sets d_reg=0 and returns to IDLE; done is not asserted.
  - If abort and cmd_valid occur in the same cycle, abort wins and the command is not accepted.
  - abort in IDLE is a no-op.
- busy is combinational from state. done is registered.
- Reset asserted mid-SCAN or mid-PULSE clears everything immediately, asynchronously, with no done.
- d_reg is always one-hot or zero; two bits are never set simultaneously.
- Width rules: all address arithmetic is N bits, wrapping. The dwell counter is 8 bits.

Decomposition:
- Package decoder_pkg holds:
  - mode localparams MODE_LEVEL=2'b00, MODE_PULSE=2'b01, MODE_SCAN=2'b10, MODE_CLEAR=2'b11;
  - state encoding ST_IDLE, ST_LEVEL, ST_PULSE, ST_SCAN (2 bits).
- Sub-module decoder_onehot: combinational N:2^N, address in, one-hot out, no enable. It is instantiated once to produce the next-state d_reg value.

Test Plan:
- Reset, then LEVEL addr=5 with en=1 -> d=16'h0020 from the cycle after accept and held; busy=0. Dropping en -> d=0 while cur_addr stays 5. Then LEVEL addr=9 -> d=16'h0200 with no zero cycle in between.
- PULSE addr=15 -> d=16'h8000 for exactly 1 cycle, then d=0 with done=1 in the same cycle; cmd_ready=0 while busy.
- SCAN addr=14, last=1, DWELL=2 -> d walks 0x4000, 0x8000, 0x0001, 0x0002, each for 2 cycles (8 total); done after the last step; cmd_valid held high is ignored until IDLE.
- SCAN addr=3, last=8, abort after 3 cycles -> d=0 the next cycle, no done, cmd_ready=1. abort with a simultaneous cmd_valid -> command not accepted.
- rst asserted asynchronously mid-SCAN (between edges) -> d=0, busy=0, cur_addr=0 immediately. After release, CLEAR from LEVEL addr=2 -> d=0, no done.
- Random-command check against a reference model for N=3 and N=5: d is always one-hot or zero, and done count equals completed PULSE+SCAN commands.
